// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the PRBS checker.
//   chk_state_t    - lock FSM state encoding
//   DEFAULT_TAPS_8 - x^8+x^6+x^5+x^4+1 feedback mask (Fibonacci form)
//   lfsr_parity    - next-bit prediction: XOR of the tapped stages
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;

    // Registers up to 32 stages are supported; callers zero-extend.
    function automatic logic lfsr_parity(input logic [31:0] sreg,
                                         input logic [31:0] taps);
        return ^(sreg & taps);
    endfunction

endpackage

// File: rtl/prbs_lock_fsm.sv
// prbs_lock_fsm: lock acquisition / loss state machine for the PRBS checker.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   valid      - a received bit is present this cycle
//   match      - received bit equals the local prediction
//   sreg_zero  - local shift register is all zeros (lockup state)
//   lock       - registered lock indication
//   flywheel   - local register must shift its own prediction, not the input
//
// state  | meaning
// SEED   | loading WIDTH received bits into the local register
// VERIFY | checking predictions against the stream before trusting it
// LOCKED | flywheel running; mismatches fill a leaky bucket
module prbs_lock_fsm
    import lfsr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic match,
    input  logic sreg_zero,
    output logic lock,
    output logic flywheel
);

    localparam int SEED_W   = $clog2(WIDTH + 1);
    localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
    localparam int BUCKET_W = $clog2(LOSS_THRESH + 1);

    localparam logic [SEED_W-1:0]   SEED_LAST   = SEED_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [BUCKET_W-1:0] BUCKET_LAST = BUCKET_W'(LOSS_THRESH - 1);

    chk_state_t            state, state_n;
    logic [SEED_W-1:0]     seed_cnt, seed_cnt_n;
    logic [MATCH_W-1:0]    match_cnt, match_cnt_n;
    logic [BUCKET_W-1:0]   bucket, bucket_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEED;
            seed_cnt  <= '0;
            match_cnt <= '0;
            bucket    <= '0;
            lock      <= 1'b0;
        end else begin
            state     <= state_n;
            seed_cnt  <= seed_cnt_n;
            match_cnt <= match_cnt_n;
            bucket    <= bucket_n;
            lock      <= (state_n == LOCKED);
        end
    end

    always_comb begin
        state_n     = state;
        seed_cnt_n  = seed_cnt;
        match_cnt_n = match_cnt;
        bucket_n    = bucket;
        if (valid) begin
            case (state)
                SEED: begin
                    if (seed_cnt == SEED_LAST) begin
                        state_n     = VERIFY;
                        seed_cnt_n  = '0;
                        match_cnt_n = '0;
                    end else begin
                        seed_cnt_n = seed_cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    // An all-zero register would predict zeros forever.
                    if (!match || sreg_zero) begin
                        state_n    = SEED;
                        seed_cnt_n = '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state_n  = LOCKED;
                        bucket_n = '0;
                    end else begin
                        match_cnt_n = match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        if (bucket == BUCKET_LAST) begin
                            state_n    = SEED;
                            seed_cnt_n = '0;
                            bucket_n   = '0;
                        end else begin
                            bucket_n = bucket + 1'b1;
                        end
                    end else if (bucket != '0) begin
                        bucket_n = bucket - 1'b1;
                    end
                end
                default: begin
                    state_n    = SEED;
                    seed_cnt_n = '0;
                end
            endcase
        end
    end

    assign flywheel = (state == LOCKED);

endmodule

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: self-synchronising PRBS checker with flywheel and
// saturating bit-error counter.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - in_bit is valid this cycle
//   in_bit     - received serial PRBS bit
//   clr_count  - synchronous clear of err_count (and bit_count)
//   lock       - checker is locked to the stream
//   err_pulse  - one-cycle pulse after a mismatching valid bit while locked
//   err_count  - saturating mismatch count while locked
//   bit_count  - saturating count of bits compared while locked
//                (only when LFSR_CHK_BITCNT_EN is defined)
// Build option: define LFSR_CHK_BITCNT_EN to add bit_count.
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEFAULT_TAPS_8),
    parameter int               LOCK_COUNT  = 16,
    parameter int               LOSS_THRESH = 8,
    parameter int               ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 clr_count,
    output logic                 lock,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITCNT_EN
    ,
    output logic [31:0]          bit_count
`endif
);

    logic [WIDTH-1:0] sreg;
    logic             pred;
    logic             match;
    logic             flywheel;
    logic             bit_err;

    assign pred    = lfsr_parity(32'(sreg), 32'(TAPS));
    assign match   = (in_bit == pred);
    assign bit_err = in_valid && flywheel && !match;

    prbs_lock_fsm #(
        .WIDTH       (WIDTH),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .valid     (in_valid),
        .match     (match),
        .sreg_zero (sreg == '0),
        .lock      (lock),
        .flywheel  (flywheel)
    );

    // In flywheel mode the register feeds on its own prediction so a
    // corrupted input bit does not propagate into later predictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= bit_err;
            if (in_valid) begin
                sreg <= {sreg[WIDTH-2:0], flywheel ? pred : in_bit};
            end
            if (clr_count) begin
                err_count <= '0;
            end else if (bit_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

`ifdef LFSR_CHK_BITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            bit_count <= '0;
        end else if (in_valid && flywheel && (bit_count != '1)) begin
            bit_count <= bit_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
module tb_lfsr_prbs_checker;

    localparam int WIDTH       = 8;
    localparam int LOCK_COUNT  = 16;
    localparam int LOSS_THRESH = 8;
    localparam int ERR_CNT_W   = 16;

    localparam int M_SEED   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic clr_count = 1'b0;
    logic lock;
    logic err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef LFSR_CHK_BITCNT_EN
    logic [31:0] bit_count;
`endif

    always #5 clk = ~clk;

    lfsr_prbs_checker #(
        .WIDTH       (WIDTH),
        .TAPS        (8'hB8),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSS_THRESH (LOSS_THRESH),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_count (clr_count),
        .lock      (lock),
        .err_pulse (err_pulse),
        .err_count (err_count)
`ifdef LFSR_CHK_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference stream generator ----------------
    logic [7:0] tap_mask = 8'hB8;
    logic [7:0] gen_state = 8'h01;

    task automatic gen_bit(output logic b);
        b = ^(gen_state & tap_mask);
        gen_state = {gen_state[6:0], b};
    endtask

    // ---------------- behavioural model ----------------
    // Holds the last WIDTH bits the checker believes were sent (index 0 newest)
    // and the lock phase, following the rules of the state machine directly.
    logic        m_hist [WIDTH];
    int          m_mode = M_SEED;
    int          m_seeds = 0;
    int          m_matches = 0;
    int          m_bucket = 0;
    logic        m_lock = 1'b0;
    logic        m_pulse = 1'b0;
    logic [15:0] m_cnt = 16'h0;
    logic [31:0] m_bits = 32'h0;

    task automatic push_hist(input logic b);
        for (int i = WIDTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = b;
    endtask

    always @(posedge clk) begin : model
        logic pred;
        logic allzero;
        logic mis;
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) m_hist[i] = 1'b0;
            m_mode = M_SEED; m_seeds = 0; m_matches = 0; m_bucket = 0;
            m_pulse = 1'b0; m_cnt = 16'h0; m_bits = 32'h0;
        end else begin
            m_pulse = 1'b0;
            if (in_valid) begin
                pred = 1'b0;
                allzero = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    if (tap_mask[i]) pred = pred ^ m_hist[i];
                    if (m_hist[i]) allzero = 1'b0;
                end
                mis = (in_bit != pred);
                if (m_mode == M_SEED) begin
                    push_hist(in_bit);
                    m_seeds++;
                    if (m_seeds == WIDTH) begin m_mode = M_VERIFY; m_matches = 0; end
                end else if (m_mode == M_VERIFY) begin
                    push_hist(in_bit);
                    if (mis || allzero) begin
                        m_mode = M_SEED; m_seeds = 0;
                    end else begin
                        m_matches++;
                        if (m_matches == LOCK_COUNT) begin m_mode = M_LOCKED; m_bucket = 0; end
                    end
                end else begin
                    push_hist(pred);
                    if (m_bits != 32'hFFFF_FFFF) m_bits++;
                    if (mis) begin
                        m_pulse = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt++;
                        m_bucket++;
                        if (m_bucket == LOSS_THRESH) begin
                            m_mode = M_SEED; m_seeds = 0; m_bucket = 0;
                        end
                    end else if (m_bucket > 0) begin
                        m_bucket--;
                    end
                end
            end
            if (clr_count) begin m_cnt = 16'h0; m_bits = 32'h0; end
        end
        m_lock = (m_mode == M_LOCKED);
    end

    // ---------------- compare process ----------------
    logic chk_en = 1'b0;
    int   pulse_seen = 0;
    int   lock_seen = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("lock", 32'(lock), 32'(m_lock));
            check("err_pulse", 32'(err_pulse), 32'(m_pulse));
            check("err_count", 32'(err_count), 32'(m_cnt));
`ifdef LFSR_CHK_BITCNT_EN
            check("bit_count", bit_count, m_bits);
`endif
            if (err_pulse === 1'b1) pulse_seen++;
            if (lock === 1'b1) lock_seen++;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_raw(input logic v, input logic b, input logic clr);
        @(negedge clk);
        rst = 1'b0;
        in_valid = v;
        in_bit = b;
        clr_count = clr;
    endtask

    task automatic drive(input logic v, input logic flip, input logic clr);
        logic b;
        if (v) gen_bit(b);
        else b = 1'($urandom_range(0, 1));
        drive_raw(v, v ? (b ^ flip) : b, clr);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_bit = 1'($urandom_range(0, 1));
        clr_count = 1'($urandom_range(0, 1));
        settle();
    endtask

    initial begin
        logic [7:0] first8;
        logic b;
        int p0;
        int l0;
        int vcount;
        logic v;
        int burst_left;

        // Pin the generator: seed 01 with taps B8 emits 0,0,0,1,1,1,0,0.
        for (int i = 0; i < 8; i++) begin
            gen_bit(b);
            first8 = {first8[6:0], b};
        end
        check("gen_first8", 32'(first8), 32'h1C);
        gen_state = 8'h01;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);

        // Clean lock: 8 seed + 16 verify bits.
        p0 = pulse_seen;
        for (int i = 1; i <= 200; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            settle();
            if (i == 23) check("clean_lock_bit23", 32'(lock), 32'd0);
            if (i == 24) check("clean_lock_bit24", 32'(lock), 32'd1);
        end
        check("clean_err_count", 32'(err_count), 32'd0);
        check("clean_pulses", 32'(pulse_seen - p0), 32'd0);

        // Single flipped bit while locked.
        p0 = pulse_seen;
        for (int i = 1; i <= 150; i++) begin
            drive(1'b1, 1'(i == 100), 1'b0);
            settle();
        end
        check("single_err_count", 32'(err_count), 32'd1);
        check("single_pulses", 32'(pulse_seen - p0), 32'd1);
        check("single_lock", 32'(lock), 32'd1);

        // Burst of 8 flipped bits drops lock; 24 clean bits relock.
        drive(1'b0, 1'b0, 1'b1);
        settle();
        check("clr_err_count", 32'(err_count), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            settle();
            if (i == 7) check("burst_lock_7", 32'(lock), 32'd1);
            if (i == 8) check("burst_lock_8", 32'(lock), 32'd0);
        end
        check("burst_err_count", 32'(err_count), 32'd8);
        for (int i = 1; i <= 24; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            settle();
            if (i == 23) check("relock_23", 32'(lock), 32'd0);
            if (i == 24) check("relock_24", 32'(lock), 32'd1);
        end
        check("relock_err_kept", 32'(err_count), 32'd8);

        // clr_count in the same cycle as a counted error.
        repeat (5) begin drive(1'b1, 1'b0, 1'b0); settle(); end
        drive(1'b1, 1'b1, 1'b1);
        settle();
        check("clr_err_count_0", 32'(err_count), 32'd0);
        check("clr_err_pulse", 32'(err_pulse), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        settle();
        check("clr_pulse_drop", 32'(err_pulse), 32'd0);

        // Three isolated errors, then reset.
        for (int i = 1; i <= 30; i++) begin
            drive(1'b1, 1'(i % 10 == 5), 1'b0);
            settle();
        end
        check("pre_rst_err_count", 32'(err_count), 32'd3);
        check("pre_rst_lock", 32'(lock), 32'd1);
        do_reset();
        check("mid_rst_lock", 32'(lock), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);

        // All-zero input never locks.
        l0 = lock_seen;
        for (int i = 0; i < 100; i++) begin
            drive_raw(1'b1, 1'b0, 1'b0);
            settle();
        end
        check("zero_never_lock", 32'(lock_seen - l0), 32'd0);

        // Gapped valid: lock after the 24th valid bit (from SEED after reset).
        do_reset();
        vcount = 0;
        for (int c = 0; c < 100; c++) begin
            v = (c % 2 == 0);
            drive(v, 1'b0, 1'b0);
            settle();
            if (v) vcount++;
            if (v && vcount == 23) check("gap_lock_23", 32'(lock), 32'd0);
            if (v && vcount == 24) check("gap_lock_24", 32'(lock), 32'd1);
        end
        p0 = pulse_seen;
        for (int c = 0; c < 40; c++) begin
            drive(1'(c % 2 == 0), 1'(c == 20), 1'b0);
            settle();
        end
        check("gap_err_count", 32'(err_count), 32'd1);
        check("gap_pulses", 32'(pulse_seen - p0), 32'd1);
        check("gap_lock", 32'(lock), 32'd1);

        // Randomised traffic against the model.
        burst_left = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 99) < 75);
                if ($urandom_range(0, 399) == 0) burst_left = $urandom_range(3, 10);
                if (v && burst_left > 0) begin
                    burst_left--;
                    drive(v, 1'b1, 1'($urandom_range(0, 199) == 0));
                end else begin
                    drive(v, 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
                end
                settle();
            end
        end

        drive(1'b0, 1'b0, 1'b0);
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
